// File: rtl/ntt_pkg.sv
// Shared NTT datapath types: transform size, word type and FSM encoding.
package ntt_pkg;
  localparam int N     = 8;
  localparam int W     = 8;
  localparam int LOG_N = 3;

  typedef logic [W-1:0] word_t;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;
endpackage

// File: rtl/mod_mac.sv
// Combinational modular multiply-accumulate: res = (acc + a*b mod q) mod q.
// acc is assumed already reduced (< q). Moduli below 2 force a zero result.
module mod_mac
  import ntt_pkg::*;
(
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] res
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   qd;
  logic [W-1:0]   pm;
  logic [W:0]     sum;

  // Full product, reduce, then one conditional subtract on the W+1 bit sum.
  always_comb begin
    qd   = (q < W'(2)) ? W'(1) : q;
    prod = a * b;
    pm   = W'(prod % (2*W)'(qd));
    sum  = {1'b0, acc} + {1'b0, pm};
    if (sum >= {1'b0, q}) sum = sum - {1'b0, q};
    res  = (q < W'(2)) ? '0 : sum[W-1:0];
  end

endmodule

// File: rtl/naive_intt_seq.sv
// Sequential naive inverse NTT, N=8: buffer 8 coefficients, run one MAC per
// cycle (8 MACs + 1 scale per output), then stream y[0..7] out.
module naive_intt_seq
  import ntt_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic [W-1:0]        mod,
  input  logic [N-1:0][W-1:0] inv_omegas,
  input  logic [W-1:0]        n_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  output logic                busy
);

  localparam logic [1:0] S_LOAD    = LOAD;
  localparam logic [1:0] S_COMPUTE = COMPUTE;
  localparam logic [1:0] S_DRAIN   = DRAIN;

  logic [1:0]           state;
  logic [LOG_N-1:0]     ld_cnt;
  logic [LOG_N:0]       j;       // 0..7 MAC, 8 = scale cycle
  logic [LOG_N-1:0]     k;       // output index, shared by COMPUTE and DRAIN
  word_t                acc;
  logic [N-1:0][W-1:0]  x_buf;
  logic [N-1:0][W-1:0]  y_buf;
  word_t                q_r;
  word_t                n_inv_r;
  logic [N-1:0][W-1:0]  iw_r;

  word_t                q_cur;
  word_t                x_red;
  word_t                mac_acc, mac_a, mac_b, mac_res;
  logic [LOG_N-1:0]     jk_idx;

  // The first word of a block is reduced with the live modulus, since the
  // captured copy only lands on that same edge.
  assign q_cur  = (ld_cnt == '0) ? mod : q_r;
  assign jk_idx = LOG_N'(j[LOG_N-1:0] * k);

  mod_mac u_reduce (
    .acc (W'(0)),
    .a   (in_data),
    .b   (W'(1)),
    .q   (q_cur),
    .res (x_red)
  );

  // One shared MAC: accumulate x[j]*iw[j*k] or, on the scale cycle, acc*n_inv.
  always_comb begin
    mac_acc = '0;
    mac_a   = x_buf[j[LOG_N-1:0]];
    mac_b   = iw_r[jk_idx];
    if (j[LOG_N]) begin
      mac_a = acc;
      mac_b = n_inv_r;
    end else if (j != '0) begin
      mac_acc = acc;
    end
  end

  mod_mac u_mac (
    .acc (mac_acc),
    .a   (mac_a),
    .b   (mac_b),
    .q   (q_r),
    .res (mac_res)
  );

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign out_data  = out_valid ? y_buf[k] : '0;
  assign out_last  = out_valid && (k == '1);
  assign busy      = !((state == S_LOAD) && (ld_cnt == '0));

  // FSM, counters, buffers and captured configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LOAD;
      ld_cnt  <= '0;
      j       <= '0;
      k       <= '0;
      acc     <= '0;
      x_buf   <= '0;
      y_buf   <= '0;
      q_r     <= '0;
      n_inv_r <= '0;
      iw_r    <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            x_buf[ld_cnt] <= x_red;
            if (ld_cnt == '0) begin
              q_r     <= mod;
              n_inv_r <= n_inv;
              iw_r    <= inv_omegas;
            end
            ld_cnt <= ld_cnt + (LOG_N)'(1);
            if (ld_cnt == '1) begin
              state <= S_COMPUTE;
              j     <= '0;
              k     <= '0;
            end
          end
        end
        S_COMPUTE: begin
          if (!j[LOG_N]) begin
            acc <= mac_res;
            j   <= j + (LOG_N+1)'(1);
          end else begin
            y_buf[k] <= mac_res;
            j        <= '0;
            k        <= k + (LOG_N)'(1);
            if (k == '1) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            k <= k + (LOG_N)'(1);
            if (k == '1) state <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_naive_intt_seq.sv
// Directed bench for naive_intt_seq with hand-computed expected transforms.
module tb_naive_intt_seq;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [7:0]       mod;
  logic [7:0][7:0]  inv_omegas;
  logic [7:0]       n_inv;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;

  naive_intt_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mod        (mod),
    .inv_omegas (inv_omegas),
    .n_inv      (n_inv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  localparam logic [7:0][7:0] IW17 =
    {8'd9, 8'd13, 8'd15, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_acc = 0;
  int last_acc = 0;
  logic [7:0] res [8];
  logic       lastf [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [7:0] v [8], input logic [7:0] q,
                            input logic [7:0][7:0] iw, input logic [7:0] ni,
                            input bit gaps);
    mod = q; inv_omegas = iw; n_inv = ni;
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick;
      in_valid = 1'b1;
      in_data  = v[i];
      tick;
      if (i == 0) first_acc = cyc;
      last_acc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic drain(input bit stall);
    int got = 0;
    int guard = 0;
    logic pv = 1'b0;
    logic [7:0] pd = '0;
    while (got < 8 && guard < 200) begin
      out_ready = stall ? ((guard % 4 == 0) || (guard % 4 == 3)) : 1'b1;
      if (pv) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd)
          $display("FAIL stall_hold: valid=%b data=%0d, required valid=1 data=%0d",
                   out_valid, out_data, pd);
        if (out_valid !== 1'b1 || out_data !== pd) errors++;
      end
      pv = out_valid && !out_ready;
      pd = out_data;
      if (out_valid && out_ready) begin
        res[got]   = out_data;
        lastf[got] = out_last;
        got++;
      end
      tick;
      guard++;
    end
    out_ready = 1'b0;
    if (got < 8) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d results, required 8", got);
    end
  endtask

  task automatic test_reset;
    #12;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: %b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: %b, required 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: %b, required 0", out_last); end
    if (out_data !== 8'd0) begin errors++; $display("FAIL rst_out_data: %0d, required 0", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_round_trip;
    logic [7:0] v [8] = '{6, 7, 7, 9, 2, 5, 6, 0};
    logic [7:0] e [8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    int n;
    load_block(v, 8'd17, IW17, 8'd15, 1'b0);
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rt_in_ready_low: %b, required 0", in_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL rt_busy: %b, required 1", busy); end
    wait_valid(n);
    checks++;
    if (n != 72) begin errors++; $display("FAIL rt_latency: %0d cycles, required 72", n); end
    drain(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks += 2;
      if (res[i] !== e[i]) begin errors++; $display("FAIL rt_y%0d: %0d, required %0d", i, res[i], e[i]); end
      if (lastf[i] !== (i == 7)) begin errors++; $display("FAIL rt_last%0d: %b, required %b", i, lastf[i], i == 7); end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rt_after_last: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_impulse;
    logic [7:0] v [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int n;
    load_block(v, 8'd17, IW17, 8'd15, 1'b0);
    wait_valid(n);
    checks++;
    if (n != 72) begin errors++; $display("FAIL imp_latency: %0d cycles, required 72", n); end
    drain(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res[i] !== 8'd15) begin errors++; $display("FAIL imp_y%0d: %0d, required 15", i, res[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] v [8] = '{6, 7, 7, 9, 2, 5, 6, 0};
    logic [7:0] e [8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    int n;
    load_block(v, 8'd17, IW17, 8'd15, 1'b1);
    wait_valid(n);
    checks++;
    if (n != 72) begin errors++; $display("FAIL bp_latency: %0d cycles, required 72", n); end
    drain(1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res[i] !== e[i]) begin errors++; $display("FAIL bp_y%0d: %0d, required %0d", i, res[i], e[i]); end
    end
  endtask

  task automatic test_out_of_range;
    logic [7:0] v [8] = '{23, 24, 24, 26, 19, 22, 23, 17};
    logic [7:0] e [8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    int n;
    load_block(v, 8'd17, IW17, 8'd15, 1'b0);
    tick;
    mod = 8'd251;
    inv_omegas = {$urandom, $urandom};
    n_inv = 8'd3;
    wait_valid(n);
    checks++;
    if (n != 71) begin errors++; $display("FAIL oor_latency: %0d cycles, required 71", n); end
    drain(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res[i] !== e[i]) begin errors++; $display("FAIL oor_y%0d: %0d, required %0d", i, res[i], e[i]); end
    end
  endtask

  task automatic test_illegal_q;
    logic [7:0] v [8] = '{6, 7, 7, 9, 2, 5, 6, 0};
    int n;
    load_block(v, 8'd1, IW17, 8'd15, 1'b0);
    wait_valid(n);
    checks++;
    if (n != 72) begin errors++; $display("FAIL q1_latency: %0d cycles, required 72", n); end
    drain(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res[i] !== 8'd0) begin errors++; $display("FAIL q1_y%0d: %0d, required 0", i, res[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] v [8] = '{6, 7, 7, 9, 2, 5, 6, 0};
    logic [7:0] imp [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int n;
    load_block(v, 8'd17, IW17, 8'd15, 1'b0);
    repeat (20) tick;
    rst_n = 1'b0;
    #2;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: %b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: %b, required 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: %b, required 0", busy); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    load_block(imp, 8'd17, IW17, 8'd15, 1'b0);
    wait_valid(n);
    checks++;
    if (n != 72) begin errors++; $display("FAIL mid_latency: %0d cycles, required 72", n); end
    drain(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res[i] !== 8'd15) begin errors++; $display("FAIL mid_y%0d: %0d, required 15", i, res[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v [8] = '{6, 7, 7, 9, 2, 5, 6, 0};
    logic [7:0] imp [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int n;
    int f1;
    load_block(v, 8'd17, IW17, 8'd15, 1'b0);
    f1 = first_acc;
    wait_valid(n);
    drain(1'b0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_rise: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    load_block(imp, 8'd17, IW17, 8'd15, 1'b0);
    checks++;
    if (first_acc - f1 != 88) begin errors++; $display("FAIL b2b_period: %0d cycles, required 88", first_acc - f1); end
    wait_valid(n);
    drain(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res[i] !== 8'd15) begin errors++; $display("FAIL b2b_y%0d: %0d, required 15", i, res[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mod = 8'd17; inv_omegas = IW17; n_inv = 8'd15;
    test_reset;
    test_round_trip;
    test_impulse;
    test_backpressure;
    test_out_of_range;
    test_illegal_q;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/naive_intt_seq.md
# naive_intt_seq

Sequential inverse number-theoretic transform, N = 8, 8-bit residues, run-time modulus. It undoes the naive forward NTT used in the same datapath. Coefficients stream in over a valid/ready port and are buffered. The block then evaluates y[k] = n_inv · Σ_j x[j]·iw^(j·k mod 8) mod q with one multiply-accumulate per cycle, and streams the results out in natural order.

## Interface
Parameters:
- N, 8, transform length (fixed; power of two; indexes are LOG_N = 3 bits)
- W, 8, residue / data word width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data holds a coefficient
- in_ready  out  1  block accepts a coefficient this cycle
- in_data  in  W  coefficient x[j], j = acceptance order 0..7
- mod  in  W  modulus q
- inv_omegas  in  W×N  iw^0..iw^7, powers of the inverse primitive root
- n_inv  in  W  N^-1 mod q
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream takes the result
- out_data  out  W  result y[k], k = 0..7 in order
- out_last  out  1  high with y[7]
- busy  out  1  high outside LOAD with count 0

## Operation
- States:
  - LOAD: in_ready = 1. Accept words on in_valid & in_ready.
  - COMPUTE: 72 cycles.
  - DRAIN: present results.
- LOAD→COMPUTE after the 8th accept.
- COMPUTE→DRAIN after the last scale cycle.
- DRAIN→LOAD on the handshake where out_last = 1.
- Configuration is captured on the first accepted word of a block: mod, inv_omegas and n_inv go into registers. Port changes after that have no effect until the next block.
- Load: x[j] ← in_data mod q. Inputs ≥ q are reduced on entry.
- COMPUTE per output k = 0..7:
  - 8 MAC cycles, j = 0..7: acc ← (acc + x[j]·iw[(j·k) & 7] mod q) mod q. acc is cleared at the start of each k.
  - 1 scale cycle: y[k] ← acc·n_inv mod q.
- Arithmetic:
  - Product is 2W bits, reduced by mod q.
  - Sum is W+1 bits, with one conditional subtract of q.
  - All stored values are < q.
- q < 2 is illegal. The block then produces y = 0 everywhere and still follows the normal timing.
- DRAIN:
  - out_data = y[k] and out_valid = 1.
  - k advances only on out_valid & out_ready.
  - out_last = (k == 7).
- in_valid outside LOAD is ignored (in_ready = 0). There is no overlap of load and drain.

## Timing
- Reset values:
  - state = LOAD, in_ready = 1
  - out_valid = 0, out_last = 0, out_data = 0, busy = 0
  - all counters, acc, x and y buffers = 0
- Reset asserted mid-block aborts immediately. Partial data is discarded and no out_valid follows.
- Last input accepted at cycle t:
  - in_ready = 0 from t+1.
  - COMPUTE occupies t+1..t+72.
  - out_valid = 1 from t+73.
- DRAIN with out_ready held high: one result per cycle, 8 cycles.
- After the last handshake at cycle u: in_ready = 1 and out_valid = 0 at u+1.
- Back-to-back minimum block period: 8 + 72 + 8 = 88 cycles.
- out_valid stays high and out_data stays stable while out_ready = 0 (standard valid/ready; valid never depends on ready).
- in_valid gaps during LOAD stall loading without losing count.

## Structure
- Shared package ntt_pkg:
  - N, W, LOG_N
  - state enum {LOAD, COMPUTE, DRAIN}
  - word_t typedef, reused by the forward NTT.
- Sub-module mod_mac (combinational): (acc, a, b, q) → (acc + a·b mod q) mod q, with a q < 2 → 0 guard.
  - Used for the MAC cycles.
  - Also used for scaling with acc = 0, a = acc, b = n_inv.
- Top contains:
  - FSM
  - j/k counters
  - x and y register files
  - captured-config registers

## Test plan
- Round trip, q = 17, inv_omegas = {1,2,4,8,16,15,13,9}, n_inv = 15, input {6,7,7,9,2,5,6,0} → out {1,2,3,0,0,0,0,0}, out_valid 73 cycles after the last accept, out_last on the 8th word.
- Impulse {1,0,0,0,0,0,0,0}, same config → every y = 15.
- Backpressure: out_ready toggled 1,0,0,1,… with a random in_valid gap pattern → identical ordered results, out_data stable while stalled, no drops or duplicates.
- Out-of-range input {23,24,…} (≥ 17) → equals the result for the inputs reduced mod 17; mod/inv_omegas changed during COMPUTE → no effect on the current block.
- rst_n pulsed low during COMPUTE, then a fresh block loaded → in_ready = 1 and out_valid = 0 immediately after reset; correct results for the new block only.
- Two back-to-back blocks with out_ready = 1 → second block's in_ready rises the cycle after the first block's out_last handshake; total 88-cycle period.
